// File: rtl/cnu_minsum_serial.sv
// rtl/cnu_minsum_serial.sv - serial offset-min-sum check-node accumulator
// Tracks min1/min2/index/sign product over one row of sign-magnitude messages.
module cnu_minsum_serial #(
    parameter int DATA_W  = 9,
    parameter int MAX_DEG = 32,
    parameter int IDX_W   = $clog2(MAX_DEG),
    parameter int OFFSET  = 1
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_valid,
    input  logic [DATA_W-1:0] i_data,
    input  logic              i_last,
    output logic              o_ready,
    output logic              o_valid,
    input  logic              i_ready,
    output logic [DATA_W-2:0] o_min1,
    output logic [DATA_W-2:0] o_min2,
    output logic [IDX_W-1:0]  o_min_idx,
    output logic              o_sign_prod,
    output logic [IDX_W-1:0]  o_deg,
    output logic              o_ovf
);
    localparam int MAG_W = DATA_W - 1;

    typedef enum logic {ST_ACC, ST_HOLD} state_t;

    state_t             state;
    logic [MAG_W-1:0]   acc_min1;
    logic [MAG_W-1:0]   acc_min2;
    logic [IDX_W-1:0]   acc_idx;
    logic [IDX_W-1:0]   cnt;
    logic               acc_sign;

    logic [MAG_W-1:0]   mag;
    logic [MAG_W-1:0]   nx_min1;
    logic [MAG_W-1:0]   nx_min2;
    logic [IDX_W-1:0]   nx_idx;
    logic               nx_sign;
    logic               accept;
    logic               at_max;
    logic               close;

    // Saturating subtract: the offset must never wrap a small magnitude upward.
    function automatic logic [MAG_W-1:0] sub_off(input logic [MAG_W-1:0] m);
        return (m > MAG_W'(OFFSET)) ? m - MAG_W'(OFFSET) : '0;
    endfunction

    assign o_ready = (state == ST_ACC);
    assign accept  = i_valid && o_ready;
    assign at_max  = (cnt == IDX_W'(MAX_DEG - 1));
    assign close   = i_last || at_max;

    always_comb begin
        mag     = i_data[MAG_W-1:0];
        nx_min1 = acc_min1;
        nx_min2 = acc_min2;
        nx_idx  = acc_idx;
        nx_sign = acc_sign ^ i_data[DATA_W-1];
        // Strict compares keep the earliest index on ties.
        if (mag < acc_min1) begin
            nx_min2 = acc_min1;
            nx_min1 = mag;
            nx_idx  = cnt;
        end else if (mag < acc_min2) begin
            nx_min2 = mag;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state       <= ST_ACC;
            o_valid     <= 1'b0;
            o_min1      <= '0;
            o_min2      <= '0;
            o_min_idx   <= '0;
            o_sign_prod <= 1'b0;
            o_deg       <= '0;
            o_ovf       <= 1'b0;
            acc_min1    <= '1;
            acc_min2    <= '1;
            acc_idx     <= '0;
            cnt         <= '0;
            acc_sign    <= 1'b0;
        end else begin
            case (state)
                ST_ACC: begin
                    if (accept) begin
                        if (close) begin
                            o_min1      <= sub_off(nx_min1);
                            o_min2      <= sub_off(nx_min2);
                            o_min_idx   <= nx_idx;
                            o_sign_prod <= nx_sign;
                            o_deg       <= cnt;
                            o_ovf       <= at_max && !i_last;
                            o_valid     <= 1'b1;
                            state       <= ST_HOLD;
                            acc_min1    <= '1;
                            acc_min2    <= '1;
                            acc_idx     <= '0;
                            cnt         <= '0;
                            acc_sign    <= 1'b0;
                        end else begin
                            acc_min1 <= nx_min1;
                            acc_min2 <= nx_min2;
                            acc_idx  <= nx_idx;
                            acc_sign <= nx_sign;
                            cnt      <= cnt + IDX_W'(1);
                        end
                    end
                end
                ST_HOLD: begin
                    if (i_ready) begin
                        o_valid <= 1'b0;
                        state   <= ST_ACC;
                    end
                end
                default: state <= ST_ACC;
            endcase
        end
    end
endmodule
